// File: rtl/dla_pe_array_result_drain_if.sv
// rtl/dla_pe_array_result_drain_if.sv - PE array result capture and output beat stream bundle
interface dla_pe_array_result_drain_if #(
  parameter int unsigned NUM_LANES             = 1,
  parameter int unsigned NUM_RESULTS_PER_CYCLE = 2,
  parameter int unsigned NUM_FEATURES          = 4,
  parameter int unsigned RESULT_WIDTH          = 32
);
  localparam int unsigned WORD_W = NUM_LANES * NUM_RESULTS_PER_CYCLE * NUM_FEATURES * RESULT_WIDTH;
  localparam int unsigned BEAT_W = NUM_LANES * NUM_FEATURES * RESULT_WIDTH;
  localparam int unsigned BW     = (NUM_RESULTS_PER_CYCLE > 1) ? $clog2(NUM_RESULTS_PER_CYCLE) : 1;

  logic              i_result_valid;
  logic [WORD_W-1:0] i_result;
  logic              o_almost_full;
  logic              o_overflow;
  logic              o_valid;
  logic              i_ready;
  logic [BEAT_W-1:0] o_data;
  logic [BW-1:0]     o_beat_idx;
  logic              o_last;

  modport slave (
    input  i_result_valid, i_result, i_ready,
    output o_almost_full, o_overflow, o_valid, o_data, o_beat_idx, o_last
  );

  modport master (
    output i_result_valid, i_result, i_ready,
    input  o_almost_full, o_overflow, o_valid, o_data, o_beat_idx, o_last
  );
endinterface

// File: rtl/dla_pe_array_result_drain.sv
// rtl/dla_pe_array_result_drain.sv - buffers PE array result words and serializes them one result index per beat
module dla_pe_array_result_drain #(
  parameter int unsigned NUM_LANES             = 1,
  parameter int unsigned NUM_RESULTS_PER_CYCLE = 2,
  parameter int unsigned NUM_FEATURES          = 4,
  parameter int unsigned RESULT_WIDTH          = 32,
  parameter int unsigned FIFO_DEPTH            = 16,
  parameter int unsigned ALMOST_FULL_SLACK     = 4
) (
  input  logic clk,
  input  logic i_sclr,
  dla_pe_array_result_drain_if.slave bus
);
  localparam int unsigned WORD_W = NUM_LANES * NUM_RESULTS_PER_CYCLE * NUM_FEATURES * RESULT_WIDTH;
  localparam int unsigned BEAT_W = NUM_LANES * NUM_FEATURES * RESULT_WIDTH;
  localparam int unsigned BW     = (NUM_RESULTS_PER_CYCLE > 1) ? $clog2(NUM_RESULTS_PER_CYCLE) : 1;
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;

  localparam logic [BW-1:0] LAST_IDX = BW'(NUM_RESULTS_PER_CYCLE - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(FIFO_DEPTH - ALMOST_FULL_SLACK);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q, count_d;
  logic [BW-1:0]     r_q, r_d;
  logic              af_q, ovf_q;
  logic [WORD_W-1:0] head;
  logic              beat_last, fire, pop, push, drop;

  assign head      = mem[rd_ptr];
  assign beat_last = (state_q == STREAM) && (r_q == LAST_IDX);
  assign fire      = (state_q == STREAM) && bus.i_ready;
  assign pop       = fire && beat_last;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push      = bus.i_result_valid && ((count_q != DEPTH_C) || pop);
  assign drop      = bus.i_result_valid && !push;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (fire) begin
      r_d = beat_last ? '0 : r_q + BW'(1);
    end
    state_d = (count_d == '0) ? IDLE : STREAM;
  end

  always_comb begin
    bus.o_data = '0;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      for (int f = 0; f < int'(NUM_FEATURES); f++) begin
        bus.o_data[(l * int'(NUM_FEATURES) + f) * int'(RESULT_WIDTH) +: RESULT_WIDTH] =
          head[((l * int'(NUM_RESULTS_PER_CYCLE) + int'(r_q)) * int'(NUM_FEATURES) + f)
               * int'(RESULT_WIDTH) +: RESULT_WIDTH];
      end
    end
  end

  assign bus.o_valid       = (state_q == STREAM);
  assign bus.o_last        = beat_last;
  assign bus.o_beat_idx    = r_q;
  assign bus.o_almost_full = af_q;
  assign bus.o_overflow    = ovf_q;

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      r_q     <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      wr_ptr  <= wr_ptr + PW'(push);
      rd_ptr  <= rd_ptr + PW'(pop);
      af_q    <= (count_d >= AF_C);
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !i_sclr) begin
      mem[wr_ptr] <= bus.i_result;
    end
  end
endmodule

// File: tb/tb_dla_pe_array_result_drain.sv
// tb/tb_dla_pe_array_result_drain.sv - directed bench with a queue-level reference model for the result drain
module tb_dla_pe_array_result_drain;
  localparam int NL = 1, NR = 2, NF = 4, W = 32, DEPTH = 16, SLACK = 4;
  localparam int WORD_W = NL * NR * NF * W;
  localparam int BEAT_W = NL * NF * W;

  logic clk = 1'b0;
  logic sclr;
  int   checks = 0;
  int   errors = 0;
  int   beats  = 0;
  bit   started = 0;

  logic [WORD_W-1:0] mq[$];
  int                mr;
  bit                movf, maf;

  dla_pe_array_result_drain_if #(
    .NUM_LANES(NL), .NUM_RESULTS_PER_CYCLE(NR), .NUM_FEATURES(NF), .RESULT_WIDTH(W)
  ) bus ();

  dla_pe_array_result_drain #(
    .NUM_LANES(NL), .NUM_RESULTS_PER_CYCLE(NR), .NUM_FEATURES(NF), .RESULT_WIDTH(W),
    .FIFO_DEPTH(DEPTH), .ALMOST_FULL_SLACK(SLACK)
  ) dut (
    .clk   (clk),
    .i_sclr(sclr),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] make_word(input int seed);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int l = 0; l < NL; l++)
      for (int r = 0; r < NR; r++)
        for (int f = 0; f < NF; f++)
          w[((l * NR + r) * NF + f) * W +: W] = 32'(seed * 256 + l * 4096 + r * 16 + f);
    return w;
  endfunction

  function automatic logic [BEAT_W-1:0] beat_of(input logic [WORD_W-1:0] w, input int r);
    logic [BEAT_W-1:0] b;
    b = '0;
    for (int l = 0; l < NL; l++)
      for (int f = 0; f < NF; f++)
        b[(l * NF + f) * W +: W] = w[((l * NR + r) * NF + f) * W +: W];
    return b;
  endfunction

  task automatic check(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of whole words plus the index of the beat being offered.
  always @(posedge clk) begin
    bit pop, push, adv;
    if (sclr) begin
      mq.delete();
      mr      = 0;
      movf    = 0;
      maf     = 0;
      started = 1;
    end else if (started) begin
      adv  = (mq.size() > 0) && bus.i_ready;
      pop  = adv && (mr == NR - 1);
      push = bus.i_result_valid && ((mq.size() < DEPTH) || pop);
      if (bus.o_valid && bus.i_ready) beats++;
      if (adv) begin
        if (mr == NR - 1) begin
          mr = 0;
          void'(mq.pop_front());
        end else begin
          mr++;
        end
      end
      if (push) mq.push_back(bus.i_result);
      if (bus.i_result_valid && !push) movf = 1;
      maf = (mq.size() >= DEPTH - SLACK);
    end
  end

  always @(negedge clk) begin
    if (started && !sclr) begin
      check("valid", bus.o_valid, mq.size() > 0);
      check("almost_full", bus.o_almost_full, maf);
      check("overflow", bus.o_overflow, movf);
      check("last", bus.o_last, (mq.size() > 0) && (mr == NR - 1));
      if (mq.size() > 0) begin
        check("data", bus.o_data, beat_of(mq[0], mr));
        check("beat_idx", bus.o_beat_idx, mr);
      end
    end
  end

  task automatic push_word(input int seed);
    bus.i_result_valid = 1'b1;
    bus.i_result       = make_word(seed);
    @(negedge clk);
    bus.i_result_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.i_ready = 1'b1;
    while (bus.o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.o_valid, 1'b0);
  endtask

  initial begin
    int b0, bubbles;
    sclr               = 1'b1;
    bus.i_result_valid = 1'b0;
    bus.i_result       = '0;
    bus.i_ready        = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_valid", bus.o_valid, 1'b0);
    check("reset_af", bus.o_almost_full, 1'b0);
    sclr = 1'b0;

    // 1: single word, two beats
    b0 = beats;
    push_word(5);
    check("t1_b0_data", bus.o_data, {32'h503, 32'h502, 32'h501, 32'h500});
    check("t1_b0_idx", bus.o_beat_idx, 0);
    check("t1_b0_last", bus.o_last, 0);
    @(negedge clk);
    check("t1_b1_data", bus.o_data, {32'h513, 32'h512, 32'h511, 32'h510});
    check("t1_b1_last", bus.o_last, 1);
    @(negedge clk);
    check("t1_idle", bus.o_valid, 0);
    check("t1_beats", beats - b0, 2);

    // 2: ready stall on beat 1
    b0 = beats;
    bus.i_ready = 1'b0;
    push_word(6);
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("t2_held_idx", bus.o_beat_idx, 1);
    check("t2_held_data", bus.o_data, {32'h613, 32'h612, 32'h611, 32'h610});
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("t2_beats", beats - b0, 2);

    // 3: fill, almost-full threshold, overflow, ordered drain
    b0 = beats;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_word(16 + i);
      if (i == 10) check("t3_af_after11", bus.o_almost_full, 0);
      if (i == 11) check("t3_af_after12", bus.o_almost_full, 1);
    end
    check("t3_ovf_before", bus.o_overflow, 0);
    push_word(99);
    check("t3_ovf_set", bus.o_overflow, 1);
    drain("t3_drained");
    check("t3_beats", beats - b0, 32);
    check("t3_ovf_sticky", bus.o_overflow, 1);

    // 4: push and pop together at full
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    b0 = beats;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_word(200 + i);
    bus.i_ready = 1'b1;
    @(negedge clk);
    push_word(300);
    check("t4_ovf", bus.o_overflow, 0);
    check("t4_af", bus.o_almost_full, 1);
    drain("t4_drained");
    check("t4_beats", beats - b0, 34);

    // 5: reset while an entry is mid-flight
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(400 + i);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    check("t5_valid", bus.o_valid, 0);
    check("t5_af", bus.o_almost_full, 0);
    bus.i_ready = 1'b1;
    push_word(500);
    check("t5_idx", bus.o_beat_idx, 0);
    check("t5_data", bus.o_data, {32'h1f403, 32'h1f402, 32'h1f401, 32'h1f400});
    repeat (2) @(negedge clk);

    // 6: one word every two cycles, no bubbles
    b0 = beats;
    bubbles = 0;
    for (int i = 0; i < 100; i++) begin
      bus.i_result_valid = 1'b1;
      bus.i_result       = make_word(600 + i);
      @(negedge clk);
      if (!bus.o_valid) bubbles++;
      bus.i_result_valid = 1'b0;
      @(negedge clk);
      if (!bus.o_valid) bubbles++;
    end
    check("t6_bubbles", bubbles, 0);
    repeat (2) @(negedge clk);
    check("t6_beats", beats - b0, 200);
    check("t6_ovf", bus.o_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/dla_pe_array_result_drain.md
Name: dla_pe_array_result_drain

Overview:
- Receiving end of the PE array result interface.
- Captures each valid PE array result word (all lanes × results × features) into a FIFO, then serializes it onto a ready/valid stream.
- Each output beat carries one result index across all lanes and features.
- The PE array result interface has no backpressure, so the block exposes almost-full for upstream throttling and a sticky overflow flag.
- Sits between the PE array and the output/activation path.

Parameters:
NUM_LANES, 1, lanes in the result word
NUM_RESULTS_PER_CYCLE, 2, result indices per word; equals the number of output beats per entry (≥1)
NUM_FEATURES, 4, features per lane per result
RESULT_WIDTH, 32, bits per result element
FIFO_DEPTH, 16, entries; power of 2, ≥4
ALMOST_FULL_SLACK, 4, almost-full asserts when count ≥ FIFO_DEPTH − ALMOST_FULL_SLACK; must be < FIFO_DEPTH

Ports:
clk  input  1  clock
i_sclr  input  1  synchronous reset, active high
i_result_valid  input  1  result word valid; no backpressure
i_result  input  NUM_LANES*NUM_RESULTS_PER_CYCLE*NUM_FEATURES*RESULT_WIDTH  result word; packed [lane][result][feature][bit], lane most significant
o_almost_full  output  1  throttle request to the PE array control sequencer
o_overflow  output  1  sticky; a valid word was dropped
o_valid  output  1  output beat valid
i_ready  input  1  downstream ready
o_data  output  NUM_LANES*NUM_FEATURES*RESULT_WIDTH  beat payload; packed [lane][feature]
o_beat_idx  output  $clog2(NUM_RESULTS_PER_CYCLE) (min 1)  result index of the current beat
o_last  output  1  last beat of the entry

Behaviour:
- Interface: one clock, `clk`; reset `i_sclr` is synchronous and active-high.
- Reset values: count = 0, write/read pointers = 0, beat index = 0. Outputs o_valid = 0, o_last = 0, o_almost_full = 0, o_overflow = 0. o_data is don't-care while o_valid = 0.
- Reset mid-operation: all buffered entries are discarded, including a partially sent entry. The stream restarts at beat 0 for the next captured word.
- State: FIFO storage, registered count (0..FIFO_DEPTH), and beat counter r.
  - Beat counter states: IDLE (count = 0) and STREAM (count > 0; head entry being serialized).
- Push: occurs when i_result_valid = 1 and (count < FIFO_DEPTH or pop this cycle). The word is written at the write pointer, and the pointer wraps modulo FIFO_DEPTH.
- Drop: i_result_valid = 1 with count = FIFO_DEPTH and no pop in the same cycle drops the word. o_overflow is set on the next cycle and holds until reset.
- Output:
  - o_valid = (count > 0).
  - o_data = head[lane][r][feature] for all lanes and features.
  - o_beat_idx = r.
  - o_last = o_valid & (r == NUM_RESULTS_PER_CYCLE − 1).
- Handshake:
  - On o_valid & i_ready: if not o_last, r increments. If o_last, r returns to 0 and the head is popped, with the read pointer wrapping.
  - No bubble between entries: if count > 1 at the pop, the next entry's beat 0 is presented on the following cycle.
  - o_valid must not drop, and o_data/o_beat_idx must not change, while o_valid = 1 and i_ready = 0.
- Latency: a word pushed at cycle t with the FIFO empty presents beat 0 at t+1. No combinational path from i_result_valid to o_valid.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop: unchanged
- o_almost_full: registered, equal to (count_next ≥ FIFO_DEPTH − ALMOST_FULL_SLACK).
- Degenerate case NUM_RESULTS_PER_CYCLE = 1: every beat has o_last = 1, and o_beat_idx is tied to 0.
- Throughput: one output beat per cycle when i_ready = 1. Sustained input rate without loss is ≤ 1 word per NUM_RESULTS_PER_CYCLE cycles.

Test Plan:
1. Single word; default parameters; i_ready = 1 → two beats at t+1 and t+2.
   - o_beat_idx = 0 then 1; o_last only on the 2nd beat.
   - Each beat's o_data matches the slices [r] of the input word.
   - o_valid = 0 afterwards.
2. Ready stall: i_ready = 0 for 5 cycles mid-entry → o_data and o_beat_idx held constant; no beat lost or duplicated.
3. Fill and overflow with i_ready = 0:
   - After 16 pushes: count = 16; o_almost_full first seen at 1 in the cycle after the 12th push.
   - 17th word is dropped and o_overflow = 1.
   - After draining: the 16 original words appear in order; o_overflow stays at 1.
4. Simultaneous push and pop at full: i_ready = 1 on the last beat while i_result_valid = 1 and count = 16 → word accepted, count stays 16, o_overflow stays 0.
5. Reset mid-entry: assert i_sclr while beat 0 of an entry is held and 3 entries are buffered → next cycle o_valid = 0 and o_almost_full = 0. A new word then starts at o_beat_idx = 0.
6. Back-to-back words every 2 cycles with i_ready = 1 → continuous o_valid with no bubbles, count ≤ 1, no overflow over 100 words; output order equals input order.
